pulse_monitor: RTL
==================

// Module: pulse_monitor
// PURPOSE
//   Receive-side checker for the periodic single-cycle pulse produced by the timer block.
//   Detects rising edges on `pulse`, measures the cycle count between consecutive edges,
//   and reports each measured period. Acquires lock after LOCK_CNT consecutive good periods.
//   Flags short and long (missing) periods. Sits in the testbench/monitor path next to the timer.
// PARAMETERS
//   EXP_PERIOD  12  expected edge-to-edge period in clock cycles (timer default: 12)
//   LOCK_CNT    3   consecutive good periods required to assert `locked`
//   TOL         1   +/- period tolerance in cycles; used only when PULSE_MONITOR_TOL_EN is defined
//   CNT_W       8   period counter width; must hold EXP_PERIOD+TOL+1
// PORTS
//   clock         in   1      rising-edge clock, single clock domain
//   reset_n       in   1      synchronous, active-low reset
//   pulse         in   1      monitored pulse; may be high for more than one cycle, rising edge counts
//   period        out  CNT_W  last measured edge-to-edge period
//   period_valid  out  1      one-cycle strobe: `period` updated
//   locked        out  1      high while in LOCK state
//   err_short     out  1      one-cycle strobe: edge arrived with period < EXP_LO
//   err_long      out  1      one-cycle strobe: no edge by EXP_HI cycles after last edge
//   err_count     out  8      saturating count of err_short + err_long events
// BEHAVIOUR
//   - Reset (reset_n low at clock edge): all outputs 0, pulse_q=0, gap=0, good_cnt=0, state=IDLE.
//     Reset applies mid-operation with the same result. A pulse held high across reset release
//     produces an edge on the first clock after release.
//   - Edge: edge = pulse & ~pulse_q; pulse_q is pulse registered every clock.
//   - gap counter: on edge gap<=1; else gap<=gap+1, saturating at all-ones.
//   - Period = gap value at the edge clock. Example: pulse high at edges t0 and t0+12 gives period=12.
//   - Window: EXP_LO=EXP_PERIOD-TOL_E, EXP_HI=EXP_PERIOD+TOL_E. TOL_E=TOL with macro, else 0.
//   - All outputs are registered. Strobes are visible the cycle after the edge clock (1-cycle latency).
//   - FSM:
//     IDLE: no reference edge. On edge: ->ACQ, good_cnt=0, no period_valid (no prior edge).
//     ACQ/LOCK, edge, EXP_LO<=gap<=EXP_HI: period_valid=1, period=gap, good_cnt++ (sat LOCK_CNT).
//       In ACQ, ->LOCK when the increment reaches LOCK_CNT; locked=1 from that same strobe cycle.
//     ACQ/LOCK, edge, gap<EXP_LO: period_valid=1, err_short=1, good_cnt=0, ->ACQ.
//       The current edge becomes the new reference.
//     ACQ/LOCK, no edge, gap==EXP_HI: err_long=1, good_cnt=0, ->IDLE. Fires once per loss.
//     Leaving LOCK drops locked with the error strobe.
//   - err_short and err_long are mutually exclusive in a cycle.
//   - err_count +1 per error strobe; holds at 255.
//   - period holds its value between strobes.
// CONFIGURATION
//   PULSE_MONITOR_TOL_EN defined: accept periods in [EXP_PERIOD-TOL, EXP_PERIOD+TOL].
//     Timeout fires at gap==EXP_PERIOD+TOL.
//   PULSE_MONITOR_TOL_EN undefined: exact match only (TOL ignored).
//     Timeout fires at gap==EXP_PERIOD.
// TESTING
//   1. Lock: 1-cycle pulses every 12 clocks, defaults -> first edge gives no strobe;
//      period_valid with period=12 on edges 2-4; locked=1 with the 4th-edge strobe; no errors.
//   2. Short: locked, then next edge after 7 clocks -> period=7, err_short=1, locked=0,
//      err_count=1; the following 3 x 12-clock periods relock.
//   3. Missing: locked, pulse stops -> err_long exactly once, 1 cycle after gap reaches 12.
//      Then locked=0, state IDLE; the next edge gives no period_valid.
//   4. Tolerance (macro on, TOL=1): periods 11, 13, 12 are accepted -> lock.
//      Period 10 -> err_short. Same 11/13 stimulus with macro off -> err_short / err_long.
//   5. Reset mid-lock: reset_n=0 for 1 clock -> all outputs 0, err_count=0.
//      Pulse held high across release -> counted as the first reference edge.
//   6. Saturation: 300 consecutive 7-clock periods -> err_count stops at 255; locked stays 0.

Source files
------------

// File: rtl/pulse_monitor.sv
// Period checker for the timer's periodic pulse: measures edge-to-edge gaps, locks, flags errors.
// Define PULSE_MONITOR_TOL_EN to accept periods within +/-TOL of EXP_PERIOD.
module pulse_monitor #(
  parameter int EXP_PERIOD = 12,
  parameter int LOCK_CNT   = 3,
  parameter int TOL        = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_short,
  output logic             err_long,
  output logic [7:0]       err_count
);

`ifdef PULSE_MONITOR_TOL_EN
  localparam int TOL_E = TOL;
`else
  // TOL stays in the parameter list so both builds share one interface
  localparam int TOL_E = TOL * 0;
`endif

  localparam logic [CNT_W-1:0] EXP_LO = CNT_W'(EXP_PERIOD - TOL_E);
  localparam logic [CNT_W-1:0] EXP_HI = CNT_W'(EXP_PERIOD + TOL_E);
  localparam int               GW     = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    GMAX   = GW'(LOCK_CNT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  logic             pulse_q;
  logic [CNT_W-1:0] gap;
  logic [GW-1:0]    good_cnt;
  logic [GW-1:0]    good_d;
  logic [GW-1:0]    good_inc;
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic             edge_det;
  logic             pv_d;
  logic             short_d;
  logic             long_d;

  assign edge_det = pulse & ~pulse_q;
  assign good_inc = (good_cnt == GMAX) ? good_cnt : good_cnt + 1'b1;

  always_comb begin
    state_d = state;
    good_d  = good_cnt;
    pv_d    = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    if (state != ACQ && state != LOCK) begin
      // no reference edge yet: the first edge only arms the gap counter
      state_d = edge_det ? ACQ : IDLE;
      good_d  = '0;
    end else begin
      unique case (1'b1)
        edge_det && gap < EXP_LO: begin
          pv_d    = 1'b1;
          short_d = 1'b1;
          good_d  = '0;
          state_d = ACQ;
        end
        edge_det && gap >= EXP_LO: begin
          pv_d   = 1'b1;
          good_d = good_inc;
          if (good_inc == GMAX) state_d = LOCK;
        end
        !edge_det && gap == EXP_HI: begin
          long_d  = 1'b1;
          good_d  = '0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pulse_q      <= 1'b0;
      gap          <= '0;
      good_cnt     <= '0;
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_count    <= '0;
    end else begin
      pulse_q      <= pulse;
      state        <= state_d;
      good_cnt     <= good_d;
      period_valid <= pv_d;
      err_short    <= short_d;
      err_long     <= long_d;
      locked       <= (state_d == LOCK);
      if (edge_det)
        gap <= CNT_W'(1);
      else if (~&gap)
        gap <= gap + 1'b1;
      if (pv_d)
        period <= gap;
      if ((short_d || long_d) && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

endmodule
